// File: rtl/edsac_lcd_text_feeder.sv
// EDSAC teleprinter code FIFO + letter/figure decoder feeding an HD44780 byte stream.
// Optional: define EDSAC_LCD_AUTOSCROLL_EN to clear the display whenever the cursor wraps past the last row.
module edsac_lcd_text_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int COLS       = 16,
  parameter int ROWS       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [4:0]               in_code,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic                     out_rs,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic                     fig_mode,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic [1:0]               cur_row
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(COLS);
  // First character of each string is code 0 (MSB end of the packed literal).
  localparam logic [255:0] LETS = "PQWERTYUIOJ#SZK*.F@D!HNM&LXGABCV";
  localparam logic [255:0] FIGS = {"0123456789?#", 8'h22, "+(*.$@;!#,.&)/#-?:="};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHAR,
    S_ADDR
`ifdef EDSAC_LCD_AUTOSCROLL_EN
    , S_CLEAR
`endif
  } state_t;

  state_t      state;
  logic [4:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, last_row, last_col;
  logic [4:0]  head;
  logic [7:0]  char_byte;

  function automatic logic [7:0] ddram(input logic [1:0] row, input logic [CW-1:0] col);
    logic [6:0] base;
    case (row)
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = 7'h14;
      default: base = 7'h54;
    endcase
    return 8'h80 | {1'b0, base + 7'(col)};
  endfunction

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign last_row  = (cur_row == 2'(ROWS-1));
  assign last_col  = (cur_col == CW'(COLS-1));
  assign char_byte = (head == 5'd20) ? 8'h20 :
                     fig_mode ? FIGS[255-8*int'(head) -: 8] : LETS[255-8*int'(head) -: 8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_code;
  end

  // Decode happens in the same cycle as the pop so one item leaves every two clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_rs    <= 1'b0;
      out_data  <= 8'h00;
      fig_mode  <= 1'b0;
      cur_col   <= '0;
      cur_row   <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        S_IDLE: if (!empty) begin
          rd_ptr <= rd_ptr + 1'b1;
          case (head)
            5'd11: fig_mode <= 1'b1;
            5'd15: fig_mode <= 1'b0;
            5'd16: if (fig_mode) begin
              out_valid <= 1'b1;
              out_rs    <= 1'b1;
              out_data  <= char_byte;
              state     <= S_CHAR;
            end
            5'd18: begin
              cur_col   <= '0;
              out_valid <= 1'b1;
              out_rs    <= 1'b0;
              out_data  <= ddram(cur_row, '0);
              state     <= S_ADDR;
            end
            5'd24: begin
              out_valid <= 1'b1;
              out_rs    <= 1'b0;
              if (last_row) begin
`ifdef EDSAC_LCD_AUTOSCROLL_EN
                out_data <= 8'h01;
                state    <= S_CLEAR;
`else
                cur_row  <= 2'd0;
                out_data <= ddram(2'd0, cur_col);
                state    <= S_ADDR;
`endif
              end else begin
                cur_row  <= cur_row + 2'd1;
                out_data <= ddram(cur_row + 2'd1, cur_col);
                state    <= S_ADDR;
              end
            end
            default: begin
              out_valid <= 1'b1;
              out_rs    <= 1'b1;
              out_data  <= char_byte;
              state     <= S_CHAR;
            end
          endcase
        end
        S_CHAR: if (out_ready) begin
          if (last_col) begin
            cur_col <= '0;
            out_rs  <= 1'b0;
            if (last_row) begin
`ifdef EDSAC_LCD_AUTOSCROLL_EN
              out_data <= 8'h01;
              state    <= S_CLEAR;
`else
              cur_row  <= 2'd0;
              out_data <= ddram(2'd0, '0);
              state    <= S_ADDR;
`endif
            end else begin
              cur_row  <= cur_row + 2'd1;
              out_data <= ddram(cur_row + 2'd1, '0);
              state    <= S_ADDR;
            end
          end else begin
            cur_col   <= cur_col + 1'b1;
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_ADDR: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
`ifdef EDSAC_LCD_AUTOSCROLL_EN
        S_CLEAR: if (out_ready) begin
          cur_col  <= '0;
          cur_row  <= 2'd0;
          out_rs   <= 1'b0;
          out_data <= 8'h80;
          state    <= S_ADDR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_edsac_lcd_text_feeder.sv
// Directed bench for edsac_lcd_text_feeder: decode, cursor tracking, wrap, backpressure, reset.
module tb_edsac_lcd_text_feeder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [4:0] in_code = 5'd0;
  logic       in_ready, out_valid, out_rs, out_ready = 1'b1, fig_mode;
  logic [7:0] out_data;
  logic [3:0] cur_col;
  logic [1:0] cur_row;
  int         n_chk = 0, n_fail = 0;
  logic [8:0] q[$];

  edsac_lcd_text_feeder #(.FIFO_DEPTH(8), .COLS(16), .ROWS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .out_valid(out_valid), .out_rs(out_rs), .out_data(out_data), .out_ready(out_ready),
    .fig_mode(fig_mode), .cur_col(cur_col), .cur_row(cur_row));

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a negedge snapshot is the handshake.
  always @(negedge clk) if (!rst && out_valid && out_ready) q.push_back({out_rs, out_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] c);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_code  = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic item(input string tag, input logic rs, input logic [7:0] d);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() > 0) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, q.pop_front(), {rs, d});
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rs", out_rs, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fig", fig_mode, 0);
    chk("rst_col", cur_col, 0);
    chk("rst_row", cur_row, 0);

    // pop in the cycle after the push, out_valid the cycle after that
    push(5'd0);
    @(negedge clk); chk("lat_pop_cycle", out_valid, 0);
    @(negedge clk); chk("lat_valid", out_valid, 1);
    push(5'd1);
    item("P", 1, "P");
    item("Q", 1, "Q");
    cyc(3);
    chk("col_after_PQ", cur_col, 2);

    push(5'd11); cyc(3);
    chk("fig_set", fig_mode, 1);
    push(5'd1);
    push(5'd15); cyc(3);
    chk("fig_clr", fig_mode, 0);
    push(5'd1);
    push(5'd16);
    push(5'd20);
    item("fig_1", 1, "1");
    item("let_Q", 1, "Q");
    item("space", 1, 8'h20);
    cyc(4);
    chk("no_extra_items", q.size(), 0);
    chk("col_after_shift", cur_col, 5);

    push(5'd11); push(5'd16); push(5'd31); push(5'd15);
    item("fig_dot", 1, ".");
    item("fig_eq", 1, "=");

    push(5'd18);
    item("cr_row0", 0, 8'h80);
    for (int i = 0; i < 16; i++) push(5'd17);
    for (int i = 0; i < 16; i++) item("F", 1, "F");
    item("wrap_addr", 0, 8'hC0);
    cyc(3);
    chk("wrap_row", cur_row, 1);
    chk("wrap_col", cur_col, 0);

    for (int i = 0; i < 5; i++) push(5'd3);
    for (int i = 0; i < 5; i++) item("E", 1, "E");
    cyc(3);
    chk("col5", cur_col, 5);
    push(5'd18);
    item("cr_row1", 0, 8'hC0);
    push(5'd24);
`ifdef EDSAC_LCD_AUTOSCROLL_EN
    item("lf_clear", 0, 8'h01);
`endif
    item("lf_home", 0, 8'h80);
    cyc(3);
    chk("lf_row", cur_row, 0);
    chk("lf_col", cur_col, 0);

    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(5'(i));
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_item", {out_rs, out_data}, {1'b1, 8'h50});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    item("bp0", 1, "P"); item("bp1", 1, "Q"); item("bp2", 1, "W");
    item("bp3", 1, "E"); item("bp4", 1, "R"); item("bp5", 1, "T");
    item("bp6", 1, "Y"); item("bp7", 1, "U"); item("bp8", 1, "I");
    cyc(4);
    chk("bp_drained", q.size(), 0);
    chk("bp_col", cur_col, 9);

    out_ready = 1'b0;
    push(5'd11); push(5'd2); push(5'd3);
    cyc(4);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_fig", fig_mode, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_col", cur_col, 0);
    chk("mid_rst_row", cur_row, 0);
    chk("mid_rst_fig", fig_mode, 0);
    out_ready = 1'b1;
    cyc(8);
    chk("mid_rst_fifo_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
